// File: rtl/ex_hilo_unit_if.sv
// ============================================================================
// ex_hilo_unit_if : EX-stage HI/LO operand, forwarding and result bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface ex_hilo_unit_if;
    logic [7:0]  aluop_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        annul_i;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        mem_whilo_i;
    logic [31:0] mem_hi_i;
    logic [31:0] mem_lo_i;
    logic        wb_whilo_i;
    logic [31:0] wb_hi_i;
    logic [31:0] wb_lo_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stallreq_o;

    modport master (
        output aluop_i, reg1_i, reg2_i, wd_i, wreg_i, annul_i, hi_i, lo_i,
               mem_whilo_i, mem_hi_i, mem_lo_i, wb_whilo_i, wb_hi_i, wb_lo_i,
        input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );

    modport slave (
        input  aluop_i, reg1_i, reg2_i, wd_i, wreg_i, annul_i, hi_i, lo_i,
               mem_whilo_i, mem_hi_i, mem_lo_i, wb_whilo_i, wb_hi_i, wb_lo_i,
        output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );
endinterface

`default_nettype wire

// File: rtl/ex_hilo_unit.sv
// ============================================================================
// ex_hilo_unit : EX-stage HI/LO moves, multiply and sequential restoring divide
// Revision 1.0
// ============================================================================
`default_nettype none

module ex_hilo_unit #(
    parameter int DIV_ITER = 32
) (
    input  wire logic     clk,
    input  wire logic     Rst_n,
    ex_hilo_unit_if.slave bus
);
    localparam logic [7:0] OP_MFHI  = 8'h10;
    localparam logic [7:0] OP_MTHI  = 8'h11;
    localparam logic [7:0] OP_MFLO  = 8'h12;
    localparam logic [7:0] OP_MTLO  = 8'h13;
    localparam logic [7:0] OP_MULT  = 8'h18;
    localparam logic [7:0] OP_MULTU = 8'h19;
    localparam logic [7:0] OP_DIV   = 8'h1A;
    localparam logic [7:0] OP_DIVU  = 8'h1B;
    localparam logic [5:0] CNT_LAST = 6'(DIV_ITER - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DBZ  = 2'd1,
        ST_ON   = 2'd2,
        ST_END  = 2'd3
    } div_state_e;

    div_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] sr_q, sr_d;
    logic [31:0] divisor_q, divisor_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;

    logic [31:0] w_fwd_hi, w_fwd_lo;
    logic        w_is_div, w_signed_div;
    logic [31:0] w_abs_a, w_abs_b;
    logic [33:0] w_trial;
    logic [32:0] w_diff;
    logic        w_fits;
    logic [31:0] w_quot, w_rem;
    logic [63:0] w_prod_s, w_prod_u;

    assign w_fwd_hi = bus.mem_whilo_i ? bus.mem_hi_i :
                      bus.wb_whilo_i  ? bus.wb_hi_i  : bus.hi_i;
    assign w_fwd_lo = bus.mem_whilo_i ? bus.mem_lo_i :
                      bus.wb_whilo_i  ? bus.wb_lo_i  : bus.lo_i;

    assign w_is_div     = (bus.aluop_i == OP_DIV) || (bus.aluop_i == OP_DIVU);
    assign w_signed_div = (bus.aluop_i == OP_DIV);
    assign w_abs_a = (w_signed_div && bus.reg1_i[31]) ? (~bus.reg1_i + 32'd1) : bus.reg1_i;
    assign w_abs_b = (w_signed_div && bus.reg2_i[31]) ? (~bus.reg2_i + 32'd1) : bus.reg2_i;

    // sr_q = {partial remainder[32:0], dividend/quotient[31:0]}; the remainder
    // never reaches bit 64 because it always stays below the divisor.
    assign w_trial = {sr_q[64:32], sr_q[31]};
    assign w_fits  = (w_trial >= {2'b00, divisor_q});
    assign w_diff  = w_trial[32:0] - {1'b0, divisor_q};

    assign w_quot = negq_q ? (~sr_q[31:0] + 32'd1)  : sr_q[31:0];
    assign w_rem  = negr_q ? (~sr_q[63:32] + 32'd1) : sr_q[63:32];

    assign w_prod_s = {{32{bus.reg1_i[31]}}, bus.reg1_i} * {{32{bus.reg2_i[31]}}, bus.reg2_i};
    assign w_prod_u = {32'd0, bus.reg1_i} * {32'd0, bus.reg2_i};

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 6'd0;
            sr_q      <= 65'd0;
            divisor_q <= 32'd0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            divisor_q <= divisor_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        divisor_d = divisor_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        if (bus.annul_i) begin
            state_d = ST_IDLE;
            cnt_d   = 6'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_is_div) begin
                        state_d   = (bus.reg2_i == 32'd0) ? ST_DBZ : ST_ON;
                        cnt_d     = 6'd0;
                        sr_d      = {33'd0, w_abs_a};
                        divisor_d = w_abs_b;
                        negq_d    = w_signed_div && (bus.reg1_i[31] ^ bus.reg2_i[31]);
                        negr_d    = w_signed_div && bus.reg1_i[31];
                    end
                end
                ST_DBZ: begin
                    sr_d    = 65'd0;
                    state_d = ST_END;
                end
                ST_ON: begin
                    sr_d = w_fits ? {w_diff, sr_q[30:0], 1'b1}
                                  : {w_trial[32:0], sr_q[30:0], 1'b0};
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_END;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 6'd0;
                end
            endcase
        end
    end

    assign bus.wd_o = bus.wd_i;

    always_comb begin
        bus.wreg_o  = 1'b0;
        bus.wdata_o = 32'd0;
        bus.whilo_o = 1'b0;
        bus.hi_o    = 32'd0;
        bus.lo_o    = 32'd0;
        case (bus.aluop_i)
            OP_MFHI: begin
                bus.wreg_o  = bus.wreg_i & ~bus.annul_i;
                bus.wdata_o = w_fwd_hi;
            end
            OP_MFLO: begin
                bus.wreg_o  = bus.wreg_i & ~bus.annul_i;
                bus.wdata_o = w_fwd_lo;
            end
            OP_MTHI: begin
                bus.whilo_o = ~bus.annul_i;
                bus.hi_o    = bus.reg1_i;
                bus.lo_o    = w_fwd_lo;
            end
            OP_MTLO: begin
                bus.whilo_o = ~bus.annul_i;
                bus.hi_o    = w_fwd_hi;
                bus.lo_o    = bus.reg1_i;
            end
            OP_MULT: begin
                bus.whilo_o = ~bus.annul_i;
                {bus.hi_o, bus.lo_o} = w_prod_s;
            end
            OP_MULTU: begin
                bus.whilo_o = ~bus.annul_i;
                {bus.hi_o, bus.lo_o} = w_prod_u;
            end
            OP_DIV, OP_DIVU: begin
                if ((state_q == ST_END) && !bus.annul_i) begin
                    bus.whilo_o = 1'b1;
                    bus.hi_o    = w_rem;
                    bus.lo_o    = w_quot;
                end
            end
            default: begin
                bus.wreg_o = bus.wreg_i & ~bus.annul_i;
            end
        endcase
    end

    assign bus.stallreq_o = ~bus.annul_i &
                            (((state_q == ST_IDLE) && w_is_div) ||
                             (state_q == ST_DBZ) || (state_q == ST_ON));

endmodule

`default_nettype wire

// File: tb/tb_ex_hilo_unit.sv
// ============================================================================
// tb_ex_hilo_unit : directed vector table plus multi-cycle divide sequences
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ex_hilo_unit;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    ex_hilo_unit_if ifc();

    ex_hilo_unit #(.DIV_ITER(32)) dut (
        .clk   (clk),
        .Rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] r1, r2, hi, lo;
        logic        mw;
        logic [31:0] mhi, mlo;
        logic        ww;
        logic [31:0] whi, wlo;
        logic        wreg, annul;
        logic        e_wreg;
        logic [31:0] e_wdata;
        logic        e_whilo;
        logic [31:0] e_hi, e_lo;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        ifc.aluop_i = 8'h00; ifc.reg1_i = 32'd0; ifc.reg2_i = 32'd0;
        ifc.wd_i = 5'd0; ifc.wreg_i = 1'b0; ifc.annul_i = 1'b0;
        ifc.hi_i = 32'd0; ifc.lo_i = 32'd0;
        ifc.mem_whilo_i = 1'b0; ifc.mem_hi_i = 32'd0; ifc.mem_lo_i = 32'd0;
        ifc.wb_whilo_i = 1'b0; ifc.wb_hi_i = 32'd0; ifc.wb_lo_i = 32'd0;
    endtask

    task automatic run_div(input string nm, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int exp_n,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int  n;
        bit  done;
        @(posedge clk); #1;
        ifc.aluop_i = op; ifc.reg1_i = a; ifc.reg2_i = b;
        ifc.annul_i = 1'b0; ifc.wreg_i = 1'b0;
        n = 0; done = 1'b0;
        while (!done && n < 40) begin
            @(negedge clk);
            if (ifc.stallreq_o) begin
                chk({nm, "_whilo_during_stall"}, 64'(ifc.whilo_o), 64'd0);
                n++;
                @(posedge clk); #1;
                // operands must have been latched; perturb them
                ifc.reg1_i = a ^ 32'h5A5A_0F0F;
                ifc.reg2_i = b + 32'd3;
            end else begin
                done = 1'b1;
            end
        end
        chk({nm, "_stall_cycles"}, 64'(n), 64'(exp_n));
        chk({nm, "_whilo"}, 64'(ifc.whilo_o), 64'd1);
        chk({nm, "_lo"}, 64'(ifc.lo_o), 64'(exp_lo));
        chk({nm, "_hi"}, 64'(ifc.hi_o), 64'(exp_hi));
        @(posedge clk); #1;
        ifc.aluop_i = 8'h00; ifc.reg1_i = 32'd0; ifc.reg2_i = 32'd0;
        @(negedge clk);
        chk({nm, "_after_stall"}, 64'(ifc.stallreq_o), 64'd0);
        chk({nm, "_after_whilo"}, 64'(ifc.whilo_o), 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        //         op     r1            r2            hi     lo     mw mhi    mlo    ww whi wlo  wr an  ewr ewdata eh   ehi           elo
        vecs[0]  = '{8'h18, 32'hFFFFFFFE, 32'd3,        32'd0, 32'd0, 0, 32'd0, 32'd0, 0, 32'd0, 32'd0, 1, 0, 0, 32'd0, 1, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{8'h19, 32'hFFFFFFFE, 32'd3,        32'd0, 32'd0, 0, 32'd0, 32'd0, 0, 32'd0, 32'd0, 1, 0, 0, 32'd0, 1, 32'd2,        32'hFFFFFFFA};
        vecs[2]  = '{8'h18, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 0, 32'd0, 32'd0, 0, 32'd0, 32'd0, 0, 0, 0, 32'd0, 1, 32'd0,        32'd1};
        vecs[3]  = '{8'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 0, 32'd0, 32'd0, 0, 32'd0, 32'd0, 0, 0, 0, 32'd0, 1, 32'hFFFFFFFE, 32'd1};
        vecs[4]  = '{8'h10, 32'd0, 32'd0, 32'd1, 32'd0, 1, 32'd3, 32'd0, 1, 32'd2, 32'd0, 1, 0, 1, 32'd3, 0, 32'd0, 32'd0};
        vecs[5]  = '{8'h10, 32'd0, 32'd0, 32'd1, 32'd0, 0, 32'd3, 32'd0, 1, 32'd2, 32'd0, 1, 0, 1, 32'd2, 0, 32'd0, 32'd0};
        vecs[6]  = '{8'h10, 32'd0, 32'd0, 32'd1, 32'd0, 0, 32'd3, 32'd0, 0, 32'd2, 32'd0, 1, 0, 1, 32'd1, 0, 32'd0, 32'd0};
        vecs[7]  = '{8'h12, 32'd0, 32'd0, 32'd0, 32'd5, 0, 32'd0, 32'd9, 1, 32'd0, 32'd6, 1, 0, 1, 32'd6, 0, 32'd0, 32'd0};
        vecs[8]  = '{8'h12, 32'd0, 32'd0, 32'd0, 32'd5, 1, 32'd0, 32'd9, 1, 32'd0, 32'd6, 1, 0, 1, 32'd9, 0, 32'd0, 32'd0};
        vecs[9]  = '{8'h13, 32'h1234, 32'd0, 32'd0, 32'd0, 1, 32'hAA, 32'hBB, 0, 32'd0, 32'd0, 1, 0, 0, 32'd0, 1, 32'hAA, 32'h1234};
        vecs[10] = '{8'h11, 32'h5678, 32'd0, 32'h22, 32'h11, 0, 32'd0, 32'd0, 0, 32'd0, 32'd0, 1, 0, 0, 32'd0, 1, 32'h5678, 32'h11};
        vecs[11] = '{8'h21, 32'd9, 32'd9, 32'd7, 32'd7, 0, 32'd0, 32'd0, 0, 32'd0, 32'd0, 1, 0, 1, 32'd0, 0, 32'd0, 32'd0};
        vecs[12] = '{8'h21, 32'd9, 32'd9, 32'd7, 32'd7, 0, 32'd0, 32'd0, 0, 32'd0, 32'd0, 1, 1, 0, 32'd0, 0, 32'd0, 32'd0};
        vecs[13] = '{8'h18, 32'd7, 32'hFFFFFFFB, 32'd0, 32'd0, 0, 32'd0, 32'd0, 0, 32'd0, 32'd0, 0, 0, 0, 32'd0, 1, 32'hFFFFFFFF, 32'hFFFFFFDD};

        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", 64'(ifc.stallreq_o), 64'd0);
        chk("reset_whilo", 64'(ifc.whilo_o), 64'd0);
        chk("reset_wreg", 64'(ifc.wreg_o), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            ifc.aluop_i = vecs[i].op; ifc.reg1_i = vecs[i].r1; ifc.reg2_i = vecs[i].r2;
            ifc.hi_i = vecs[i].hi; ifc.lo_i = vecs[i].lo;
            ifc.mem_whilo_i = vecs[i].mw; ifc.mem_hi_i = vecs[i].mhi; ifc.mem_lo_i = vecs[i].mlo;
            ifc.wb_whilo_i = vecs[i].ww; ifc.wb_hi_i = vecs[i].whi; ifc.wb_lo_i = vecs[i].wlo;
            ifc.wreg_i = vecs[i].wreg; ifc.annul_i = vecs[i].annul;
            ifc.wd_i = 5'(i + 3);
            @(negedge clk);
            chk($sformatf("v%0d_wd", i), 64'(ifc.wd_o), 64'(i + 3));
            chk($sformatf("v%0d_wreg", i), 64'(ifc.wreg_o), 64'(vecs[i].e_wreg));
            chk($sformatf("v%0d_wdata", i), 64'(ifc.wdata_o), 64'(vecs[i].e_wdata));
            chk($sformatf("v%0d_whilo", i), 64'(ifc.whilo_o), 64'(vecs[i].e_whilo));
            chk($sformatf("v%0d_hi", i), 64'(ifc.hi_o), 64'(vecs[i].e_hi));
            chk($sformatf("v%0d_lo", i), 64'(ifc.lo_o), 64'(vecs[i].e_lo));
            chk($sformatf("v%0d_stall", i), 64'(ifc.stallreq_o), 64'd0);
        end
        @(posedge clk); #1;
        clear_inputs();

        run_div("div_m7_2",    8'h1A, 32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFD, 32'hFFFFFFFF);
        run_div("div_7_m2",    8'h1A, 32'd7,        32'hFFFFFFFE, 33, 32'hFFFFFFFD, 32'd1);
        run_div("divu_100_7",  8'h1B, 32'd100,      32'd7,        33, 32'd14,       32'd2);
        run_div("divu_by0",    8'h1B, 32'd12345,    32'd0,        2,  32'd0,        32'd0);
        run_div("div_min_m1",  8'h1A, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 32'd0);

        // annul in cycle 10 of a divide
        @(posedge clk); #1;
        ifc.aluop_i = 8'h1A; ifc.reg1_i = 32'd100; ifc.reg2_i = 32'd3;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("annul_pre_stall_c%0d", c), 64'(ifc.stallreq_o), 64'd1);
            @(posedge clk); #1;
        end
        ifc.annul_i = 1'b1;
        @(negedge clk);
        chk("annul_cycle_stall", 64'(ifc.stallreq_o), 64'd0);
        chk("annul_cycle_whilo", 64'(ifc.whilo_o), 64'd0);
        @(posedge clk); #1;
        ifc.annul_i = 1'b0; ifc.aluop_i = 8'h00;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk($sformatf("annul_post_c%0d", c), {62'd0, ifc.stallreq_o, ifc.whilo_o}, 64'd0);
        end

        // reset asserted in cycle 5 of a divide
        @(posedge clk); #1;
        ifc.aluop_i = 8'h1A; ifc.reg1_i = 32'd50; ifc.reg2_i = 32'd7;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("rst_pre_stall_c%0d", c), 64'(ifc.stallreq_o), 64'd1);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; ifc.aluop_i = 8'h00;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk($sformatf("rst_post_c%0d", c), {62'd0, ifc.stallreq_o, ifc.whilo_o}, 64'd0);
        end

        run_div("divu_recover", 8'h1B, 32'd100, 32'd7, 33, 32'd14, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
